// File: rtl/operand_serializer_if.sv
// Operand load bus between the host and the bit-serial serializer.
// The master drives a parallel load; the slave returns per-lane serial bits.
interface operand_serializer_if #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 16
);
    localparam int LANES = SIZE * 8 / WIDTH;

    logic                in_valid;
    logic                in_ready;
    logic [SIZE*8-1:0]   in_data;
    logic [LANES-1:0]    lane_mask;
    logic [LANES-1:0]    ser_en;
    logic [LANES-1:0]    ser_data;
    logic                busy;
    logic                done;

    modport master (
        output in_valid,
        output in_data,
        output lane_mask,
        input  in_ready,
        input  ser_en,
        input  ser_data,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  lane_mask,
        output in_ready,
        output ser_en,
        output ser_data,
        output busy,
        output done
    );
endinterface

// File: rtl/operand_serializer.sv
// Parallel-to-serial operand loader for the systolic array SIPO inputs.
// Each accepted load shifts every lane out MSB-first, then pulses done.
module operand_serializer #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_serializer_if.slave  bus
);
    localparam int LANES = SIZE * 8 / WIDTH;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [LANES-1:0][WIDTH-1:0]   shreg_q, shreg_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic [LANES-1:0]              ser_en_q, ser_en_d;
    logic [LANES-1:0]              ser_data_q, ser_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          in_ready_q, in_ready_d;

    // Outputs are computed one edge early so every port is a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        mask_d     = mask_q;
        ser_en_d   = ser_en_q;
        ser_data_d = ser_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        in_ready_d = in_ready_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    mask_d     = bus.lane_mask;
                    ser_en_d   = bus.lane_mask;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    for (int i = 0; i < LANES; i++) begin
                        shreg_d[i]    = bus.in_data[i*WIDTH +: WIDTH];
                        ser_data_d[i] = bus.in_data[i*WIDTH + WIDTH - 1]
                                        & bus.lane_mask[i];
                    end
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    shreg_d[i] = shreg_q[i] << 1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    ser_en_d   = '0;
                    ser_data_d = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    for (int i = 0; i < LANES; i++) begin
                        ser_data_d[i] = shreg_d[i][WIDTH-1] & mask_q[i];
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                done_d     = 1'b0;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                ser_en_d   = '0;
                ser_data_d = '0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            mask_q     <= '0;
            ser_en_q   <= '0;
            ser_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            mask_q     <= mask_d;
            ser_en_q   <= ser_en_d;
            ser_data_q <= ser_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ser_en   = ser_en_q;
    assign bus.ser_data = ser_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: timeline model checked every cycle,
// plus directed loads with hand-computed serial streams.
module tb_operand_serializer;
    localparam int SIZE = 16;
    localparam int W    = 16;
    localparam int L    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   mdl_on   = 1'b0;

    operand_serializer_if #(.SIZE(SIZE), .WIDTH(W)) bus ();

    operand_serializer #(.SIZE(SIZE), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", n, a, e);
        end
    endtask

    // Model: ph counts cycles since accept (0 idle, 1..W shift, W+1 done).
    int              ph = 0;
    logic [W-1:0]    words [L];
    logic [L-1:0]    m_mask = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
        end else if (ph == 0) begin
            if (bus.in_valid) begin
                for (int i = 0; i < L; i++) words[i] = bus.in_data[i*W +: W];
                m_mask = bus.lane_mask;
                ph = 1;
            end
        end else if (ph == W + 1) begin
            ph = 0;
        end else begin
            ph++;
        end
    end

    logic          e_busy, e_done, e_rdy;
    logic [L-1:0]  e_en, e_dat;

    always @(negedge clk) begin
        if (mdl_on) begin
            e_busy = (ph >= 1 && ph <= W);
            e_done = (ph == W + 1);
            e_rdy  = (ph == 0);
            e_en   = e_busy ? m_mask : '0;
            e_dat  = '0;
            if (e_busy)
                for (int i = 0; i < L; i++) e_dat[i] = words[i][W-ph] & m_mask[i];
            chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("ser_en", 32'(bus.ser_en), 32'(e_en));
            chk("ser_data", 32'(bus.ser_data), 32'(e_dat));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] d, input logic [7:0] m,
                        input bit poke,
                        output logic [7:0][15:0] st, output int en_cyc,
                        output logic [7:0] en_or, output logic dn);
        st = '0;
        en_cyc = 0;
        en_or = '0;
        dn = 1'b0;
        bus.in_data = d;
        bus.lane_mask = m;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data = ~d;
        bus.lane_mask = ~m;
        for (int k = 1; k <= W + 1; k++) begin
            if (poke) bus.in_valid = (k >= 3 && k <= 8);
            @(negedge clk);
            if (k <= W) begin
                for (int i = 0; i < L; i++) st[i][W-k] = bus.ser_data[i];
                if (bus.busy && bus.ser_en == m) en_cyc++;
                en_or |= bus.ser_en;
            end else begin
                dn = bus.done;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    logic [7:0][15:0] st;
    int               en_cyc;
    logic [7:0]       en_or;
    logic             dn;
    int               acc_cyc [$];
    int               n_done, n_low;
    logic [127:0]     pat;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.lane_mask = '0;
        tick();
        tick();
        rst = 1'b0;
        mdl_on = 1'b1;
        repeat (3) tick();

        // 1: reset held two cycles while idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_en", 32'(bus.ser_en), 32'h0);
        chk("rst_rdy", 32'(bus.in_ready), 32'h1);
        tick();

        // 2: single lane, other lanes loaded with ones but masked
        load({{7{16'hFFFF}}, 16'hA5C3}, 8'h01, 1'b0, st, en_cyc, en_or, dn);
        chk("t2_lane0", 32'(st[0]), 32'hA5C3);
        chk("t2_en_cycles", 32'(en_cyc), 32'd16);
        chk("t2_done", 32'(dn), 32'h1);
        chk("t2_lane7", 32'(st[7]), 32'h0);

        // 3: four lanes
        load({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h7777,
              16'h1234, 16'h8000, 16'h0001, 16'hFFFF},
             8'h0F, 1'b0, st, en_cyc, en_or, dn);
        chk("t3_lane0", 32'(st[0]), 32'hFFFF);
        chk("t3_lane1", 32'(st[1]), 32'h0001);
        chk("t3_lane2", 32'(st[2]), 32'h8000);
        chk("t3_lane3", 32'(st[3]), 32'h1234);
        chk("t3_lane4", 32'(st[4]), 32'h0);
        chk("t3_en", 32'(en_or), 32'h0F);

        // 4: in_valid held high, data changes every cycle
        n_done = 0;
        n_low = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 54; c++) begin
            for (int i = 0; i < L; i++) pat[i*16 +: 16] = 16'(c * 37 + i * 4099);
            bus.in_data = pat;
            bus.lane_mask = 8'(c * 13 + 5);
            @(negedge clk);
            if (bus.in_ready) acc_cyc.push_back(c);
            else n_low++;
            if (bus.done) n_done++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t4_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("t4_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
            chk("t4_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd18);
        end
        chk("t4_dones", 32'(n_done), 32'd3);
        chk("t4_ready_low", 32'(n_low), 32'd51);
        tick();

        // 5: reset in SHIFT cycle 5 aborts the load
        bus.in_data = {8{16'hFFFF}};
        bus.lane_mask = 8'hFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_en_after_rst", 32'(bus.ser_en), 32'h0);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) n_done++;
            tick();
        end
        chk("t5_no_done", 32'(n_done), 32'd0);
        load({16'h00FF, {7{16'hAAAA}}}, 8'h80, 1'b0, st, en_cyc, en_or, dn);
        chk("t5_lane7", 32'(st[7]), 32'h00FF);
        chk("t5_lane0", 32'(st[0]), 32'h0);
        chk("t5_done", 32'(dn), 32'h1);

        // 6: empty mask, with in_valid poked during SHIFT
        load({8{16'h5A5A}}, 8'h00, 1'b1, st, en_cyc, en_or, dn);
        chk("t6_busy_cycles", 32'(en_cyc), 32'd16);
        chk("t6_en_never", 32'(en_or), 32'h0);
        chk("t6_done", 32'(dn), 32'h1);
        repeat (3) tick();

        mdl_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
